// File: rtl/maybe_rle_encoder.sv
// ---------------------------------------------------------------------------
// maybe_rle_encoder
//
// Run-length encoder for a Maybe-Word8 stream. It merges consecutive equal
// Just bytes into (byte, count) pairs. Each pair is emitted as a registered
// Maybe value. Nothing cycles are skipped and do not end the current run.
// A flush request closes the open run so that its pair can be drained.
//
// Ports:
//   clk     in   1        rising-edge clock
//   rst     in   1        synchronous active-high reset (discards open run)
//   __in0   in   1        Just flag (1 = __in1 valid)
//   __in1   in   8        payload byte
//   __in2   in   1        flush request (pulse or level)
//   __out0  out  1        Just flag of emitted pair (one-cycle pulse)
//   __out1  out  8        run byte, 0 when __out0 = 0
//   __out2  out  COUNT_W  run length 1..2^COUNT_W-1, 0 when __out0 = 0
//   __out3  out  16       pairs emitted since reset, wrapping
//                         (present only when MAYBE_RLE_STATS_EN is defined)
//
// Parameter COUNT_W (2..16) sets the width of the count field.
// ---------------------------------------------------------------------------
module maybe_rle_encoder #(
  parameter int COUNT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               __in0,
  input  logic [7:0]         __in1,
  input  logic               __in2,
  output logic               __out0,
  output logic [7:0]         __out1,
  output logic [COUNT_W-1:0] __out2
`ifdef MAYBE_RLE_STATS_EN
  ,
  output logic [15:0]        __out3
`endif
);

  // Longest run that fits in the count field (all ones).
  localparam logic [COUNT_W-1:0] MAXLEN = {COUNT_W{1'b1}};

  logic               run_active_q, run_active_d;
  logic [7:0]         run_byte_q,   run_byte_d;
  logic [COUNT_W-1:0] run_len_q,    run_len_d;
  logic               flush_pend_q, flush_pend_d;

  logic               out_valid_q,  out_valid_d;
  logic [7:0]         out_byte_q,   out_byte_d;
  logic [COUNT_W-1:0] out_len_q,    out_len_d;

  logic               flush_eff;
  logic               match;

  // A flush that could not be honoured last cycle remains active.
  assign flush_eff = __in2 | flush_pend_q;

  // run_len never exceeds MAXLEN, so "< MAXLEN" is the same as "!= MAXLEN".
  assign match = __in0 & run_active_q & (__in1 == run_byte_q) &
                 (run_len_q != MAXLEN);

  always_comb begin
    run_active_d = run_active_q;
    run_byte_d   = run_byte_q;
    run_len_d    = run_len_q;
    flush_pend_d = flush_pend_q;
    out_valid_d  = 1'b0;
    out_byte_d   = 8'd0;
    out_len_d    = '0;

    if (!__in0) begin
      // Nothing: only a flush can change anything.
      if (flush_eff) begin
        if (run_active_q) begin
          out_valid_d = 1'b1;
          out_byte_d  = run_byte_q;
          out_len_d   = run_len_q;
        end
        run_active_d = 1'b0;
        run_byte_d   = 8'd0;
        run_len_d    = '0;
        flush_pend_d = 1'b0;
      end
    end else if (match) begin
      if (flush_eff) begin
        // Fold the matching byte into the pair and close the run together.
        out_valid_d  = 1'b1;
        out_byte_d   = run_byte_q;
        out_len_d    = run_len_q + 1'b1;
        run_active_d = 1'b0;
        run_byte_d   = 8'd0;
        run_len_d    = '0;
        flush_pend_d = 1'b0;
      end else begin
        run_len_d    = run_len_q + 1'b1;
        flush_pend_d = 1'b0;
      end
    end else if (!run_active_q) begin
      // The new run cannot be flushed in the cycle that opens it, so any
      // flush request is held for the next cycle.
      run_active_d = 1'b1;
      run_byte_d   = __in1;
      run_len_d    = {{(COUNT_W-1){1'b0}}, 1'b1};
      flush_pend_d = flush_eff;
    end else begin
      // Mismatch or saturated run: emit the old pair and start a new run.
      // Only one pair can leave per cycle, so the flush is deferred.
      out_valid_d  = 1'b1;
      out_byte_d   = run_byte_q;
      out_len_d    = run_len_q;
      run_active_d = 1'b1;
      run_byte_d   = __in1;
      run_len_d    = {{(COUNT_W-1){1'b0}}, 1'b1};
      flush_pend_d = flush_eff;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_active_q <= 1'b0;
      run_byte_q   <= 8'd0;
      run_len_q    <= '0;
      flush_pend_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_byte_q   <= 8'd0;
      out_len_q    <= '0;
    end else begin
      run_active_q <= run_active_d;
      run_byte_q   <= run_byte_d;
      run_len_q    <= run_len_d;
      flush_pend_q <= flush_pend_d;
      out_valid_q  <= out_valid_d;
      out_byte_q   <= out_byte_d;
      out_len_q    <= out_len_d;
    end
  end

  assign __out0 = out_valid_q;
  assign __out1 = out_byte_q;
  assign __out2 = out_len_q;

`ifdef MAYBE_RLE_STATS_EN
  logic [15:0] stats_q, stats_d;

  // The counter updates on the same edge that loads the output pair. As a
  // result, the new count appears together with __out0 = 1.
  always_comb begin
    stats_d = stats_q + {15'd0, out_valid_d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stats_q <= 16'd0;
    end else begin
      stats_q <= stats_d;
    end
  end

  assign __out3 = stats_q;
`endif

endmodule

// File: tb/tb_maybe_rle_encoder.sv
// Self-checking bench for maybe_rle_encoder (COUNT_W = 4, MAXLEN = 15).
module tb_maybe_rle_encoder;

  localparam int COUNT_W = 4;
  localparam int MAXLEN  = 15;

  typedef struct {
    logic       v;
    logic [7:0] b;
    logic       f;
    logic       ev;
    logic [7:0] eb;
    logic [3:0] el;
  } step_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_v;
  logic [7:0] in_b;
  logic       in_f;
  logic       out_v;
  logic [7:0] out_b;
  logic [3:0] out_l;
`ifdef MAYBE_RLE_STATS_EN
  logic [15:0] out_s;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state. A Just byte is absorbed first. A flush may then
  // close the run only when that cycle has produced no pair and opened no
  // new run. Otherwise the flush carries over to the next cycle.
  bit          m_open;
  logic [7:0]  m_byte;
  int          m_len;
  bit          m_defer;
  int unsigned m_pairs;
  logic        exp_v;
  logic [7:0]  exp_b;
  logic [3:0]  exp_l;

  always #5 clk = ~clk;

  maybe_rle_encoder #(.COUNT_W(COUNT_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .__in0  (in_v),
    .__in1  (in_b),
    .__in2  (in_f),
    .__out0 (out_v),
    .__out1 (out_b),
    .__out2 (out_l)
`ifdef MAYBE_RLE_STATS_EN
    ,
    .__out3 (out_s)
`endif
  );

  // Drive one cycle, step the model, and leave time just after the edge.
  task automatic cycle(input logic v, input logic [7:0] b, input logic f,
                       input logic r);
    bit started;
    rst  = r;
    in_v = v;
    in_b = b;
    in_f = f;
    @(posedge clk);
    started = 0;
    exp_v = 1'b0;
    exp_b = 8'd0;
    exp_l = 4'd0;
    if (r) begin
      m_open = 0; m_byte = 8'd0; m_len = 0; m_defer = 0; m_pairs = 0;
    end else begin
      if (v) begin
        if (m_open && b == m_byte && m_len < MAXLEN) begin
          m_len++;
        end else begin
          if (m_open) begin
            exp_v = 1'b1; exp_b = m_byte; exp_l = 4'(m_len);
          end
          m_byte = b; m_len = 1; m_open = 1; started = 1;
        end
      end
      if (f || m_defer) begin
        if (exp_v || started) begin
          m_defer = 1;
        end else begin
          if (m_open) begin
            exp_v = 1'b1; exp_b = m_byte; exp_l = 4'(m_len);
          end
          m_open = 0; m_len = 0; m_defer = 0;
        end
      end else begin
        m_defer = 0;
      end
      if (exp_v) m_pairs++;
    end
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 8'($urandom), 1'b1, 1'b1);
      n_checks++;
      if ({out_v, out_b, out_l} !== 13'd0) begin
        n_errors++;
        $display("FAIL reset[%0d]: got v=%0d b=%02h l=%0d, want all 0",
                 k, out_v, out_b, out_l);
      end
`ifdef MAYBE_RLE_STATS_EN
      n_checks++;
      if (out_s !== 16'd0) begin
        n_errors++;
        $display("FAIL reset_stats[%0d]: got %0d, want 0", k, out_s);
      end
`endif
    end
  endtask

  task automatic test_basic_run();
    step_t t [7] = '{
      '{1'b1, 8'hAA, 1'b0, 1'b0, 8'h00, 4'd0},
      '{1'b1, 8'hAA, 1'b0, 1'b0, 8'h00, 4'd0},
      '{1'b1, 8'hAA, 1'b0, 1'b0, 8'h00, 4'd0},
      '{1'b1, 8'hBB, 1'b0, 1'b1, 8'hAA, 4'd3},
      '{1'b0, 8'h5A, 1'b0, 1'b0, 8'h00, 4'd0},
      '{1'b0, 8'h00, 1'b1, 1'b1, 8'hBB, 4'd1},
      '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 4'd0}};
    cycle(1'b0, 8'd0, 1'b0, 1'b1);
    for (int k = 0; k < 7; k++) begin
      cycle(t[k].v, t[k].b, t[k].f, 1'b0);
      n_checks++;
      if ({out_v, out_b, out_l} !== {t[k].ev, t[k].eb, t[k].el}) begin
        n_errors++;
        $display("FAIL basic[%0d]: got v=%0d b=%02h l=%0d, want v=%0d b=%02h l=%0d",
                 k, out_v, out_b, out_l, t[k].ev, t[k].eb, t[k].el);
      end
    end
  endtask

  task automatic test_saturation();
    logic       ev;
    logic [7:0] eb;
    logic [3:0] el;
    cycle(1'b0, 8'd0, 1'b0, 1'b1);
    for (int k = 0; k < 17; k++) begin
      cycle(1'b1, 8'h55, 1'b0, 1'b0);
      ev = (k == 15); eb = (k == 15) ? 8'h55 : 8'h00; el = (k == 15) ? 4'd15 : 4'd0;
      n_checks++;
      if ({out_v, out_b, out_l} !== {ev, eb, el}) begin
        n_errors++;
        $display("FAIL sat_just[%0d]: got v=%0d b=%02h l=%0d, want v=%0d b=%02h l=%0d",
                 k, out_v, out_b, out_l, ev, eb, el);
      end
      cycle(1'b0, 8'($urandom), 1'b0, 1'b0);
      n_checks++;
      if (out_v !== 1'b0) begin
        n_errors++;
        $display("FAIL sat_gap[%0d]: got v=%0d, want v=0", k, out_v);
      end
    end
    cycle(1'b0, 8'd0, 1'b1, 1'b0);
    n_checks++;
    if ({out_v, out_b, out_l} !== {1'b1, 8'h55, 4'd2}) begin
      n_errors++;
      $display("FAIL sat_flush: got v=%0d b=%02h l=%0d, want v=1 b=55 l=2",
               out_v, out_b, out_l);
    end
  endtask

  task automatic test_flush_match();
    step_t t [5] = '{
      '{1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 4'd0},
      '{1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 4'd0},
      '{1'b1, 8'h11, 1'b1, 1'b1, 8'h11, 4'd3},
      '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 4'd0},
      '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 4'd0}};
    cycle(1'b0, 8'd0, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      cycle(t[k].v, t[k].b, t[k].f, 1'b0);
      n_checks++;
      if ({out_v, out_b, out_l} !== {t[k].ev, t[k].eb, t[k].el}) begin
        n_errors++;
        $display("FAIL flush_match[%0d]: got v=%0d b=%02h l=%0d, want v=%0d b=%02h l=%0d",
                 k, out_v, out_b, out_l, t[k].ev, t[k].eb, t[k].el);
      end
    end
  endtask

  task automatic test_flush_mismatch();
    step_t t [6] = '{
      '{1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 4'd0},
      '{1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 4'd0},
      '{1'b1, 8'h22, 1'b1, 1'b1, 8'h11, 4'd2},
      '{1'b0, 8'h00, 1'b0, 1'b1, 8'h22, 4'd1},
      '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 4'd0},
      '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 4'd0}};
    cycle(1'b0, 8'd0, 1'b0, 1'b1);
    for (int k = 0; k < 6; k++) begin
      cycle(t[k].v, t[k].b, t[k].f, 1'b0);
      n_checks++;
      if ({out_v, out_b, out_l} !== {t[k].ev, t[k].eb, t[k].el}) begin
        n_errors++;
        $display("FAIL flush_mismatch[%0d]: got v=%0d b=%02h l=%0d, want v=%0d b=%02h l=%0d",
                 k, out_v, out_b, out_l, t[k].ev, t[k].eb, t[k].el);
      end
    end
`ifdef MAYBE_RLE_STATS_EN
    n_checks++;
    if (out_s !== 16'd2) begin
      n_errors++;
      $display("FAIL flush_mismatch_stats: got %0d, want 2", out_s);
    end
    cycle(1'b0, 8'd0, 1'b0, 1'b1);
    n_checks++;
    if (out_s !== 16'd0) begin
      n_errors++;
      $display("FAIL stats_after_rst: got %0d, want 0", out_s);
    end
`endif
  endtask

  task automatic test_reset_mid_run();
    cycle(1'b0, 8'd0, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) cycle(1'b1, 8'h33, 1'b0, 1'b0);
    // Reset takes priority even when a flush and a mismatching byte are present.
    cycle(1'b1, 8'h44, 1'b1, 1'b1);
    n_checks++;
    if ({out_v, out_b, out_l} !== 13'd0) begin
      n_errors++;
      $display("FAIL rst_mid_run: got v=%0d b=%02h l=%0d, want all 0",
               out_v, out_b, out_l);
    end
    cycle(1'b0, 8'd0, 1'b1, 1'b0);
    n_checks++;
    if (out_v !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_discard: got v=%0d, want v=0", out_v);
    end
    cycle(1'b1, 8'h33, 1'b0, 1'b0);
    n_checks++;
    if (out_v !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_restart: got v=%0d, want v=0", out_v);
    end
    cycle(1'b0, 8'd0, 1'b1, 1'b0);
    n_checks++;
    if ({out_v, out_b, out_l} !== {1'b1, 8'h33, 4'd1}) begin
      n_errors++;
      $display("FAIL rst_then_flush: got v=%0d b=%02h l=%0d, want v=1 b=33 l=1",
               out_v, out_b, out_l);
    end
  endtask

  task automatic test_held_flush();
    step_t t [6] = '{
      '{1'b1, 8'hAA, 1'b1, 1'b0, 8'h00, 4'd0},
      '{1'b1, 8'hAA, 1'b1, 1'b1, 8'hAA, 4'd2},
      '{1'b1, 8'hBB, 1'b1, 1'b0, 8'h00, 4'd0},
      '{1'b1, 8'hCC, 1'b1, 1'b1, 8'hBB, 4'd1},
      '{1'b0, 8'h00, 1'b1, 1'b1, 8'hCC, 4'd1},
      '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 4'd0}};
    cycle(1'b0, 8'd0, 1'b0, 1'b1);
    for (int k = 0; k < 6; k++) begin
      cycle(t[k].v, t[k].b, t[k].f, 1'b0);
      n_checks++;
      if ({out_v, out_b, out_l} !== {t[k].ev, t[k].eb, t[k].el}) begin
        n_errors++;
        $display("FAIL held_flush[%0d]: got v=%0d b=%02h l=%0d, want v=%0d b=%02h l=%0d",
                 k, out_v, out_b, out_l, t[k].ev, t[k].eb, t[k].el);
      end
    end
  endtask

  task automatic test_random();
    int          alph [3] = '{1, 2, 4};
    logic        v, f, r;
    logic [7:0]  b;
    logic [7:0]  base;
    cycle(1'b0, 8'd0, 1'b0, 1'b1);
    for (int p = 0; p < 3; p++) begin
      base = 8'($urandom);
      for (int k = 0; k < 300; k++) begin
        v = ($urandom_range(0, 9) < 7);
        b = v ? 8'(base + 8'($urandom_range(0, alph[p] - 1))) : 8'($urandom);
        f = ($urandom_range(0, 11) == 0);
        r = ($urandom_range(0, 199) == 0);
        cycle(v, b, f, r);
        n_checks++;
        if ({out_v, out_b, out_l} !== {exp_v, exp_b, exp_l}) begin
          n_errors++;
          $display("FAIL random[%0d.%0d]: got v=%0d b=%02h l=%0d, want v=%0d b=%02h l=%0d",
                   p, k, out_v, out_b, out_l, exp_v, exp_b, exp_l);
        end
`ifdef MAYBE_RLE_STATS_EN
        n_checks++;
        if (out_s !== 16'(m_pairs)) begin
          n_errors++;
          $display("FAIL random_stats[%0d.%0d]: got %0d, want %0d",
                   p, k, out_s, 16'(m_pairs));
        end
`endif
      end
    end
  endtask

  initial begin
    rst  = 1'b1;
    in_v = 1'b0;
    in_b = 8'd0;
    in_f = 1'b0;
    test_reset();
    test_basic_run();
    test_saturation();
    test_flush_match();
    test_flush_mismatch();
    test_reset_mid_run();
    test_held_flush();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/maybe_rle_encoder.md
Name: maybe_rle_encoder

Overview:
- Run-length encoder placed directly downstream of a Maybe-Word8 producer stage, which emits a 1-bit Just/Nothing flag plus an 8-bit payload.
- Collapses consecutive equal payload bytes into (byte, count) pairs and emits each pair as a Maybe-encoded output.
- Nothing cycles (flag = 0) are ignored and do not break a run.
- An explicit flush input terminates the open run so the pair can be drained.

Parameters:
COUNT_W, 4, width of run-length field; max run MAXLEN = 2^COUNT_W - 1 (legal range 2..16).

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
__in0  input  1  Just flag (1 = payload valid, 0 = Nothing)
__in1  input  8  payload byte, meaningful only when __in0 = 1
__in2  input  1  flush request, single-cycle pulse or level
__out0  output  1  Just flag for emitted pair
__out1  output  8  run byte; 0 when __out0 = 0
__out2  output  COUNT_W  run length (1..MAXLEN); 0 when __out0 = 0

Behaviour:
- Interface: one clock (clk); rst is synchronous and active-high; there is no asynchronous path.
- State registers:
  - run_active (1)
  - run_byte (8)
  - run_len (COUNT_W)
  - flush_pend (1)
  - output registers for __out0/__out1/__out2
- Reset (rst = 1 at clk edge): all state and outputs set to 0. The open run is discarded without emission. rst has priority over all inputs, including mid-run.
- Effective flush: f = __in2 OR flush_pend.
- Match condition: m = __in0 AND run_active AND (__in1 == run_byte) AND (run_len < MAXLEN).
- Per-cycle next-state rules, evaluated in priority order:
  1. __in0 = 0, f = 0: hold state, no emission.
  2. __in0 = 0, f = 1: if run_active, emit (run_byte, run_len); clear run_active, run_len = 0, flush_pend = 0.
  3. __in0 = 1, m = 1, f = 0: run_len += 1, no emission.
  4. __in0 = 1, m = 1, f = 1: emit (run_byte, run_len + 1); clear run; flush_pend = 0.
  5. __in0 = 1, run_active = 0: start run (__in1, 1). If f = 1, set flush_pend = 1, otherwise flush_pend = 0. No emission.
  6. __in0 = 1, run_active = 1, m = 0 (byte mismatch or run_len == MAXLEN): emit (run_byte, run_len); start run (__in1, 1); flush_pend = f.
- Emission count: at most one pair per cycle by construction. A flush that collides with a mismatch emission is deferred through flush_pend and re-evaluated next cycle, where the same rules apply again.
- Latency: outputs are registered. __out0 = 1 for exactly one cycle, in the cycle after the clock edge that decided the emission.
- When __out0 = 0, __out1 and __out2 are driven to 0 (Nothing encoding).
- Saturation: a run reaching MAXLEN stays open until the next Just input or flush. A further equal byte emits (byte, MAXLEN) and restarts the run at 1; counts never wrap.
- __in1 is ignored when __in0 = 0.
- __in2 held high continuously flushes every run as soon as it becomes terminable.

Optional Feature:
MAYBE_RLE_STATS_EN
- Defined:
  - Adds output port __out3, 16 bits: count of pairs emitted since reset.
  - __out3 increments in the same cycle __out0 = 1 and wraps 0xFFFF -> 0x0000.
  - rst clears it.
- Undefined: no __out3 port and no counter logic. All other behaviour is identical.

Test Plan:
- Basic run (COUNT_W = 4): Just 0xAA x3, then Just 0xBB. Required: one cycle after the 0xBB edge, __out0 = 1, __out1 = 0xAA, __out2 = 3. No other emission.
- Gaps and saturation: Just 0x55 x17, interleaved with Nothing cycles.
  - Nothing cycles do not split the run.
  - The 16th Just emits (0x55, 15).
  - Flush afterwards emits (0x55, 2).
- Flush with matching input: open run (0x11, 2), then flush + Just 0x11 in the same cycle. Required: next cycle emits (0x11, 3); run_active = 0.
- Flush with mismatching input: open run (0x11, 2), then flush + Just 0x22 with no further input. Required:
  - Emits (0x11, 2).
  - Following cycle emits (0x22, 1).
  - Then __out0 stays 0.
- Reset mid-run: run (0x33, 5), assert rst for 1 cycle. Required:
  - No emission; all outputs 0.
  - Just 0x33 then flush emits (0x33, 1).
- Stats (MAYBE_RLE_STATS_EN defined): after the flush-with-mismatch scenario from reset, __out3 = 2. After rst, __out3 = 0.
